// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic light controller.
//   state_e    : sequencer state encoding (also exported on state_o)
//   MODE_*     : mode selector codes
//   L_*        : {red,yellow,green} signal head patterns
//   head_light : signal head pattern for a given state / flash phase
//   norm_mode  : folds the unused selector code 11 onto normal operation
package traffic_pkg;

    typedef enum logic [3:0] {
        NS_GREEN  = 4'd0,
        NS_YELLOW = 4'd1,
        ALL_RED1  = 4'd2,
        EW_GREEN  = 4'd3,
        EW_YELLOW = 4'd4,
        ALL_RED2  = 4'd5,
        PED_WALK  = 4'd6,
        FLASH     = 4'd7,
        HOLD_RED  = 4'd8
    } state_e;

    localparam logic [1:0] MODE_NORMAL = 2'b00;
    localparam logic [1:0] MODE_FLASH  = 2'b01;
    localparam logic [1:0] MODE_HOLD   = 2'b10;

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;
    localparam logic [2:0] L_OFF = 3'b000;

    // Pattern shown by one head; anything not explicitly green/yellow/flash is red,
    // so an unexpected state code can only ever fail towards red.
    function automatic logic [2:0] head_light(input state_e s, input logic flash_ph,
                                              input logic is_ns);
        logic [2:0] l;
        l = L_RED;
        case (s)
            NS_GREEN:  l = is_ns ? L_GRN : L_RED;
            NS_YELLOW: l = is_ns ? L_YEL : L_RED;
            EW_GREEN:  l = is_ns ? L_RED : L_GRN;
            EW_YELLOW: l = is_ns ? L_RED : L_YEL;
            FLASH:     l = flash_ph ? L_YEL : L_OFF;
            default:   l = L_RED;
        endcase
        return l;
    endfunction

    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'b11) ? MODE_NORMAL : m;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase duration down-counter.
//   clk, rst  : clock, synchronous active-high reset (counter -> RST_VAL)
//   load      : reload with load_val (takes priority over counting)
//   load_val  : duration-1 of the phase being entered
//   tick      : timebase strobe; counter decrements only on tick, stops at zero
//   expired   : tick seen while counter is zero, i.e. the phase's last tick
module phase_timer #(
    parameter int              CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = {CNT_W{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload, tick-driven decrement, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (tick && (cnt_q != {CNT_W{1'b0}})) begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = tick && (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-way intersection sequencer with pedestrian walk phase, flash and hold-red modes.
//   clk, rst    : clock, synchronous active-high reset
//   tick        : timebase strobe; phase timers advance only when high
//   mode        : 00 normal, 01 flash, 10 hold red, 11 as normal
//   ped_req     : pedestrian button, latched into ped_pending
//   ns_light    : north-south head {red,yellow,green}
//   ew_light    : east-west head {red,yellow,green}
//   walk        : pedestrian WALK lamp
//   ped_pending : latched request not yet serviced
//   state_o     : current state code (traffic_pkg::state_e)
// All outputs come straight from flops.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 3,
    parameter int ALLRED_TICKS = 2,
    parameter int WALK_TICKS   = 6,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [1:0] mode,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic       ped_pending,
    output logic [3:0] state_o
);

    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_TICKS - 1);

    state_e           state_q, state_d;
    logic             flash_ph_q, flash_ph_d;
    logic             ped_pending_q, ped_pending_d;
    logic [2:0]       ns_light_q, ns_light_d;
    logic [2:0]       ew_light_q, ew_light_d;
    logic             walk_q, walk_d;
    logic [1:0]       mode_n_s;
    logic             expired_s;
    logic             load_s;
    logic [CNT_W-1:0] load_val_s;
    logic             enter_walk_s;

    // Timer reload value for the phase being entered. FLASH/HOLD_RED are untimed;
    // their value is never used because leaving them always reloads.
    function automatic logic [CNT_W-1:0] dur_of(input state_e s);
        logic [CNT_W-1:0] v;
        v = ALLRED_LD;
        case (s)
            NS_GREEN, EW_GREEN:   v = GREEN_LD;
            NS_YELLOW, EW_YELLOW: v = YELLOW_LD;
            PED_WALK:             v = WALK_LD;
            default:              v = ALLRED_LD;
        endcase
        return v;
    endfunction

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (ALLRED_LD)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .load_val (load_val_s),
        .tick     (tick),
        .expired  (expired_s)
    );

    // Next state: mode overrides beat the timer; otherwise advance on expiry.
    always_comb begin
        mode_n_s = norm_mode(mode);
        state_d  = state_q;
        if (mode_n_s == MODE_FLASH) begin
            state_d = FLASH;
        end else if (mode_n_s == MODE_HOLD) begin
            state_d = HOLD_RED;
        end else if ((state_q == FLASH) || (state_q == HOLD_RED)) begin
            state_d = ALL_RED2;
        end else if (expired_s) begin
            case (state_q)
                NS_GREEN:  state_d = NS_YELLOW;
                NS_YELLOW: state_d = ALL_RED1;
                ALL_RED1:  state_d = EW_GREEN;
                EW_GREEN:  state_d = EW_YELLOW;
                EW_YELLOW: state_d = ALL_RED2;
                ALL_RED2:  state_d = ped_pending_q ? PED_WALK : NS_GREEN;
                PED_WALK:  state_d = NS_GREEN;
                default:   state_d = ALL_RED2;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Every state change reloads the timer with the new phase's duration.
    always_comb begin
        load_s     = (state_d != state_q);
        load_val_s = dur_of(state_d);
    end

    // Pedestrian latch and flash phase. A request arriving on the very clk that
    // enters PED_WALK survives the clear so it is served on the next round.
    always_comb begin
        enter_walk_s  = (state_d == PED_WALK) && (state_q != PED_WALK);
        ped_pending_d = ped_req | (ped_pending_q & ~enter_walk_s);
        if ((state_q == FLASH) && (state_d == FLASH)) begin
            flash_ph_d = flash_ph_q ^ tick;
        end else begin
            flash_ph_d = 1'b0;
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        ns_light_d = head_light(state_d, flash_ph_d, 1'b1);
        ew_light_d = head_light(state_d, flash_ph_d, 1'b0);
        walk_d     = (state_d == PED_WALK);
    end

    // Sequencer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ALL_RED2;
            flash_ph_q    <= 1'b0;
            ped_pending_q <= 1'b0;
            ns_light_q    <= L_RED;
            ew_light_q    <= L_RED;
            walk_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            flash_ph_q    <= flash_ph_d;
            ped_pending_q <= ped_pending_d;
            ns_light_q    <= ns_light_d;
            ew_light_q    <= ew_light_d;
            walk_q        <= walk_d;
        end
    end

    assign ns_light    = ns_light_q;
    assign ew_light    = ew_light_q;
    assign walk        = walk_q;
    assign ped_pending = ped_pending_q;
    assign state_o     = state_q;

endmodule
